data_plane_rx: RTL and testbench
================================

# data_plane_rx

Receive stage of the data plane, directly downstream of the data-plane transmitter. Each frame on the link is one header beat followed by four data beats. The block:
- recognises frames addressed to this node and records the source node;
- buffers the four 16-bit data words in a FIFO;
- commits the words atomically, or discards the whole frame;
- signals completion with a one-cycle flag so the GPP can read the words out.

## Interface
Parameters:
- ADDR_W, 4, log2 of buffer depth (16 words at default); must be ≥ 2.
- FRAME_WORDS, 4, data beats per frame (fixed-length frames); must be ≤ 2^ADDR_W.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-low: sampled low at a rising edge resets the block.
- node_id  in  16  this node's id; 0 is reserved, so with node_id = 0 no frame is ever accepted.
- data_rx_packet  in  32  link beat, {dest[31:16], payload[15:0]}; 32'h0000_0000 = idle.
- gpp_trf_rx  in  1  GPP pop request; ignored when buffer empty.
- RAM_rx_data_out  out  16  word at FIFO head (first-word fall-through); 0 when empty.
- rx_src_node  out  16  source id of the most recently committed frame.
- rx_count  out  ADDR_W+1  words currently buffered.
- rx_empty  out  1  rx_count == 0.
- data_rx_complete_flag  out  1  one-cycle pulse: a frame was committed.
- rx_error_flag  out  1  one-cycle pulse: frame aborted on a dest mismatch.
- rx_overflow_flag  out  1  one-cycle pulse: frame received completely but dropped for lack of space.

## Operation
- States: IDLE, RECV.
- IDLE:
  - Beat with dest == node_id and node_id != 0 is a header.
  - On a header: latch payload as pending source; set beat counter to 0; snapshot space_ok = (2^ADDR_W − rx_count ≥ FRAME_WORDS) using pre-pop count; go to RECV.
  - All other beats are ignored, including idle, other-node and zero beats.
- RECV, each beat:
  - dest == node_id: treat as data, even if it looks like a header.
    - If space_ok: write payload at wr_ptr_spec; increment wr_ptr_spec.
    - Increment beat counter.
    - On beat FRAME_WORDS (last):
      - If space_ok: wr_ptr ← wr_ptr_spec; rx_count += FRAME_WORDS; rx_src_node ← pending source; pulse data_rx_complete_flag.
      - Else: pulse rx_overflow_flag.
      - Return to IDLE.
  - dest != node_id (including idle beat):
    - Abort the frame: wr_ptr_spec ← wr_ptr.
    - Pulse rx_error_flag; return to IDLE.
    - That beat is not re-examined as a header.
- Speculative writes target only free slots, so unread data is never corrupted.
- Pop: gpp_trf_rx with rx_count > 0 increments rd_ptr and decrements rx_count.
- Pointers are ADDR_W bits and wrap modulo 2^ADDR_W. rx_count is ADDR_W+1 bits and never exceeds 2^ADDR_W.
- Commit and pop in the same cycle: rx_count ← rx_count + FRAME_WORDS − 1.
- Storage is a register array written one word per cycle. The read path is combinational from rd_ptr.

## Timing
- Reset values: state IDLE; all pointers, rx_count and rx_src_node 0; all flags 0; RAM_rx_data_out 0; rx_empty 1. Buffer contents don't care.
- Reset mid-frame discards the partial frame. No flag pulses in the reset cycle.
- Latency: header at edge N, data beats at edges N+1..N+4.
  - Flag pulse, rx_count and rx_src_node update are visible after edge N+4, for exactly one cycle (flags).
  - First word is on RAM_rx_data_out after edge N+4.
- Back-to-back frames: a header may arrive on the beat immediately after a last data beat; it is accepted.
- No beat is lost on an abort or commit edge, except the mismatching beat itself.
- Pop takes effect at the edge; the next word appears after that edge.

## Test plan
- Basic frame:
  - Stimulus: node_id=5; beats 0005_0009, 0005_1111, 0005_2222, 0005_3333, 0005_4444.
  - Response: complete pulse one cycle after the 5th beat; rx_src_node=9; rx_count=4; head=1111.
  - Four pops return 1111, 2222, 3333, 4444, then rx_empty=1.
- Filtering and abort:
  - Other-dest frame (0007_…): no flags, count 0.
  - Own header, two data beats, then idle 0000_0000: rx_error_flag pulse, count 0.
  - A following valid frame commits normally.
- Overflow:
  - ADDR_W=4: commit 3 frames (count 12), send a 4th: 4 free, commits (count 16).
  - Send a 5th frame with no pops: rx_overflow_flag pulse; count stays 16; contents unchanged.
- Wrap and concurrency:
  - Commit 3 frames, pop 12, commit 2 more frames across the pointer wrap; data order is preserved.
  - Pop on the commit edge gives count 4+4−1=7.
- Reset:
  - Drive rst low after the 2nd data beat of a frame: all outputs return to reset values; no flags.
  - Frame sent after reset deasserts is accepted.
- Reserved id: node_id=0 with beats 0000_0001…: never accepted, all flags 0.

Source files
------------

// File: rtl/data_plane_rx_if.sv
// Link, node-id and GPP read-out signals of the data-plane receive stage.
// The master modport belongs to whoever drives the link and pops words. The slave modport belongs to the receiver.
interface data_plane_rx_if #(
    parameter int ADDR_W = 4
);
    logic [15:0]     node_id;
    logic [31:0]     data_rx_packet;
    logic            gpp_trf_rx;
    logic [15:0]     RAM_rx_data_out;
    logic [15:0]     rx_src_node;
    logic [ADDR_W:0] rx_count;
    logic            rx_empty;
    logic            data_rx_complete_flag;
    logic            rx_error_flag;
    logic            rx_overflow_flag;

    modport master (
        output node_id, data_rx_packet, gpp_trf_rx,
        input  RAM_rx_data_out, rx_src_node, rx_count, rx_empty,
               data_rx_complete_flag, rx_error_flag, rx_overflow_flag
    );

    modport slave (
        input  node_id, data_rx_packet, gpp_trf_rx,
        output RAM_rx_data_out, rx_src_node, rx_count, rx_empty,
               data_rx_complete_flag, rx_error_flag, rx_overflow_flag
    );
endinterface

// File: rtl/data_plane_rx.sv
// Receives header + FRAME_WORDS data beats and commits the frame atomically into a FWFT buffer. Flags appear one edge after the last beat.
// There is no link backpressure: a frame that does not fit is drained and reported with an overflow pulse.
module data_plane_rx #(
    parameter int ADDR_W      = 4,
    parameter int FRAME_WORDS = 4
) (
    input logic            clk,
    input logic            rst,
    data_plane_rx_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FW    = (ADDR_W+1)'(FRAME_WORDS);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    typedef enum logic {IDLE, RECV} state_t;

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr, wr_ptr_spec, rd_ptr;
    logic [ADDR_W:0]   rx_count, count_next, beat_cnt;
    logic [15:0]       pend_src, src_node;
    logic              space_ok;
    logic              complete_q, error_q, overflow_q;
    logic [15:0]       mem [DEPTH];

    logic [15:0] dest, payload;
    logic        match, pop, last, commit;

    assign dest    = bus.data_rx_packet[31:16];
    assign payload = bus.data_rx_packet[15:0];
    assign match   = (dest == bus.node_id) && (bus.node_id != 16'd0);
    assign pop     = bus.gpp_trf_rx && (rx_count != '0);
    assign last    = (beat_cnt == FW - 1'b1);
    assign commit  = (state == RECV) && match && last && space_ok;

    always_comb begin
        count_next = rx_count;
        if (commit) count_next = count_next + FW;
        if (pop)    count_next = count_next - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            wr_ptr_spec <= '0;
            rd_ptr      <= '0;
            rx_count    <= '0;
            beat_cnt    <= '0;
            pend_src    <= '0;
            src_node    <= '0;
            space_ok    <= 1'b0;
            complete_q  <= 1'b0;
            error_q     <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            complete_q <= 1'b0;
            error_q    <= 1'b0;
            overflow_q <= 1'b0;
            rx_count   <= count_next;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case (state)
                IDLE: begin
                    if (match) begin
                        pend_src <= payload;
                        beat_cnt <= '0;
                        // Free space is judged on the count before any same-edge pop.
                        space_ok <= (DEPTH_C - rx_count) >= FW;
                        state    <= RECV;
                    end
                end
                RECV: begin
                    if (match) begin
                        if (space_ok) wr_ptr_spec <= wr_ptr_spec + 1'b1;
                        beat_cnt <= beat_cnt + 1'b1;
                        if (last) begin
                            if (space_ok) begin
                                wr_ptr     <= wr_ptr_spec + 1'b1;
                                src_node   <= pend_src;
                                complete_q <= 1'b1;
                            end else begin
                                overflow_q <= 1'b1;
                            end
                            state <= IDLE;
                        end
                    end else begin
                        wr_ptr_spec <= wr_ptr;
                        error_q     <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Speculative writes only ever land in free slots, so unread words stay intact.
    always_ff @(posedge clk) begin
        if (rst && (state == RECV) && match && space_ok)
            mem[wr_ptr_spec] <= payload;
    end

    assign bus.RAM_rx_data_out       = (rx_count == '0) ? 16'd0 : mem[rd_ptr];
    assign bus.rx_src_node           = src_node;
    assign bus.rx_count              = rx_count;
    assign bus.rx_empty              = (rx_count == '0);
    assign bus.data_rx_complete_flag = complete_q;
    assign bus.rx_error_flag         = error_q;
    assign bus.rx_overflow_flag      = overflow_q;
endmodule

// File: tb/tb_data_plane_rx.sv
// Directed bench for data_plane_rx: filtering, abort, overflow, wrap, concurrent pop, reset and the reserved id.
module tb_data_plane_rx;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    data_plane_rx_if #(.ADDR_W(4)) bus ();

    data_plane_rx #(.ADDR_W(4), .FRAME_WORDS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic beat(input logic [31:0] b);
        bus.data_rx_packet = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        beat(32'h0);
    endtask

    task automatic pop();
        bus.data_rx_packet = 32'h0;
        bus.gpp_trf_rx = 1'b1;
        @(posedge clk);
        #1;
        bus.gpp_trf_rx = 1'b0;
    endtask

    // word i of the frame is base + i*step; optional pop on the last-beat edge
    task automatic send_frame(input logic [15:0] dst, input logic [15:0] src,
                              input logic [15:0] base, input logic [15:0] step,
                              input bit pop_last);
        beat({dst, src});
        for (int i = 0; i < 4; i++) begin
            if (i == 3 && pop_last) bus.gpp_trf_rx = 1'b1;
            beat({dst, 16'(base + 16'(i) * step)});
        end
        bus.gpp_trf_rx = 1'b0;
        bus.data_rx_packet = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.rx_count, bus.rx_empty, bus.RAM_rx_data_out, bus.rx_src_node} !== {5'd0, 1'b1, 16'd0, 16'd0}) begin
            errors++;
            $display("FAIL reset_outputs count=%0d empty=%0b head=%h src=%h want 0/1/0000/0000",
                     bus.rx_count, bus.rx_empty, bus.RAM_rx_data_out, bus.rx_src_node);
        end
        checks++;
        if ({bus.data_rx_complete_flag, bus.rx_error_flag, bus.rx_overflow_flag} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got=%b want=000",
                     {bus.data_rx_complete_flag, bus.rx_error_flag, bus.rx_overflow_flag});
        end
        rst = 1'b1;
        idle();
    endtask

    task automatic test_basic();
        logic [15:0] exp;
        send_frame(16'h0005, 16'h0009, 16'h1111, 16'h1111, 1'b0);
        checks++;
        if ({bus.data_rx_complete_flag, bus.rx_src_node, bus.rx_count, bus.RAM_rx_data_out} !== {1'b1, 16'h0009, 5'd4, 16'h1111}) begin
            errors++;
            $display("FAIL basic_commit cpl=%b src=%h count=%0d head=%h want 1/0009/4/1111",
                     bus.data_rx_complete_flag, bus.rx_src_node, bus.rx_count, bus.RAM_rx_data_out);
        end
        idle();
        checks++;
        if (bus.data_rx_complete_flag !== 1'b0) begin
            errors++;
            $display("FAIL basic_pulse_width cpl=%b want 0", bus.data_rx_complete_flag);
        end
        for (int i = 1; i <= 4; i++) begin
            exp = 16'(16'h1111 * i);
            checks++;
            if (bus.RAM_rx_data_out !== exp) begin
                errors++;
                $display("FAIL basic_pop%0d got=%h want=%h", i, bus.RAM_rx_data_out, exp);
            end
            pop();
        end
        checks++;
        if ({bus.rx_empty, bus.rx_count, bus.RAM_rx_data_out} !== {1'b1, 5'd0, 16'd0}) begin
            errors++;
            $display("FAIL basic_empty empty=%b count=%0d head=%h want 1/0/0000",
                     bus.rx_empty, bus.rx_count, bus.RAM_rx_data_out);
        end
    endtask

    task automatic test_filter();
        send_frame(16'h0007, 16'h0001, 16'hAAAA, 16'h0001, 1'b0);
        checks++;
        if ({bus.data_rx_complete_flag, bus.rx_error_flag, bus.rx_overflow_flag, bus.rx_count} !== {3'b000, 5'd0}) begin
            errors++;
            $display("FAIL filter_other_dest flags=%b count=%0d want 000/0",
                     {bus.data_rx_complete_flag, bus.rx_error_flag, bus.rx_overflow_flag}, bus.rx_count);
        end
        beat(32'h0005_0002);
        beat(32'h0005_BEE0);
        beat(32'h0005_BEE1);
        beat(32'h0000_0000);
        checks++;
        if ({bus.rx_error_flag, bus.data_rx_complete_flag, bus.rx_count} !== {2'b10, 5'd0}) begin
            errors++;
            $display("FAIL filter_abort err=%b cpl=%b count=%0d want 1/0/0",
                     bus.rx_error_flag, bus.data_rx_complete_flag, bus.rx_count);
        end
        send_frame(16'h0005, 16'h0003, 16'h00A1, 16'h0001, 1'b0);
        checks++;
        if ({bus.data_rx_complete_flag, bus.rx_src_node, bus.rx_count, bus.RAM_rx_data_out} !== {1'b1, 16'h0003, 5'd4, 16'h00A1}) begin
            errors++;
            $display("FAIL filter_after_abort cpl=%b src=%h count=%0d head=%h want 1/0003/4/00a1",
                     bus.data_rx_complete_flag, bus.rx_src_node, bus.rx_count, bus.RAM_rx_data_out);
        end
        repeat (4) pop();
    endtask

    task automatic test_back_to_back();
        beat(32'h0005_0011);
        for (int i = 0; i < 4; i++) beat({16'h0005, 16'(16'hB100 + i)});
        checks++;
        if ({bus.data_rx_complete_flag, bus.rx_count} !== {1'b1, 5'd4}) begin
            errors++;
            $display("FAIL b2b_first cpl=%b count=%0d want 1/4", bus.data_rx_complete_flag, bus.rx_count);
        end
        send_frame(16'h0005, 16'h0012, 16'hB200, 16'h0001, 1'b0);
        checks++;
        if ({bus.data_rx_complete_flag, bus.rx_src_node, bus.rx_count} !== {1'b1, 16'h0012, 5'd8}) begin
            errors++;
            $display("FAIL b2b_second cpl=%b src=%h count=%0d want 1/0012/8",
                     bus.data_rx_complete_flag, bus.rx_src_node, bus.rx_count);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (bus.RAM_rx_data_out !== 16'((i < 4) ? 16'hB100 + i : 16'hB200 + i - 4)) begin
                errors++;
                $display("FAIL b2b_order%0d got=%h", i, bus.RAM_rx_data_out);
            end
            pop();
        end
    endtask

    task automatic test_overflow();
        for (int f = 1; f <= 4; f++)
            send_frame(16'h0005, 16'(16'h0020 + f), 16'(f << 8 | 1), 16'h0001, 1'b0);
        checks++;
        if ({bus.data_rx_complete_flag, bus.rx_count} !== {1'b1, 5'd16}) begin
            errors++;
            $display("FAIL ovf_fill cpl=%b count=%0d want 1/16", bus.data_rx_complete_flag, bus.rx_count);
        end
        send_frame(16'h0005, 16'h0029, 16'hDEAD, 16'h0001, 1'b0);
        checks++;
        if ({bus.rx_overflow_flag, bus.data_rx_complete_flag, bus.rx_count, bus.rx_src_node} !== {2'b10, 5'd16, 16'h0024}) begin
            errors++;
            $display("FAIL ovf_drop ovf=%b cpl=%b count=%0d src=%h want 1/0/16/0024",
                     bus.rx_overflow_flag, bus.data_rx_complete_flag, bus.rx_count, bus.rx_src_node);
        end
        for (int f = 1; f <= 4; f++) begin
            for (int w = 1; w <= 4; w++) begin
                checks++;
                if (bus.RAM_rx_data_out !== 16'(f << 8 | w)) begin
                    errors++;
                    $display("FAIL ovf_contents f%0d w%0d got=%h want=%h", f, w, bus.RAM_rx_data_out, 16'(f << 8 | w));
                end
                pop();
            end
        end
    endtask

    task automatic test_wrap();
        for (int f = 5; f <= 7; f++) send_frame(16'h0005, 16'(f), 16'(f << 8 | 1), 16'h0001, 1'b0);
        for (int k = 0; k < 12; k++) pop();
        for (int f = 8; f <= 9; f++) send_frame(16'h0005, 16'(f), 16'(f << 8 | 1), 16'h0001, 1'b0);
        for (int f = 8; f <= 9; f++) begin
            for (int w = 1; w <= 4; w++) begin
                checks++;
                if (bus.RAM_rx_data_out !== 16'(f << 8 | w)) begin
                    errors++;
                    $display("FAIL wrap_order f%0d w%0d got=%h want=%h", f, w, bus.RAM_rx_data_out, 16'(f << 8 | w));
                end
                pop();
            end
        end
        send_frame(16'h0005, 16'h0031, 16'hC101, 16'h0001, 1'b0);
        send_frame(16'h0005, 16'h0032, 16'hC201, 16'h0001, 1'b1);
        checks++;
        if ({bus.data_rx_complete_flag, bus.rx_count, bus.RAM_rx_data_out} !== {1'b1, 5'd7, 16'hC102}) begin
            errors++;
            $display("FAIL commit_with_pop cpl=%b count=%0d head=%h want 1/7/c102",
                     bus.data_rx_complete_flag, bus.rx_count, bus.RAM_rx_data_out);
        end
        repeat (7) pop();
    endtask

    task automatic test_mid_reset();
        send_frame(16'h0005, 16'h0040, 16'hE001, 16'h0001, 1'b0);
        beat(32'h0005_0041);
        beat(32'h0005_E101);
        beat(32'h0005_E102);
        rst = 1'b0;
        beat(32'h0005_E103);
        checks++;
        if ({bus.rx_count, bus.rx_empty, bus.RAM_rx_data_out, bus.rx_src_node,
             bus.data_rx_complete_flag, bus.rx_error_flag, bus.rx_overflow_flag} !== {5'd0, 1'b1, 16'd0, 16'd0, 3'b000}) begin
            errors++;
            $display("FAIL mid_reset count=%0d empty=%b head=%h src=%h flags=%b want 0/1/0000/0000/000",
                     bus.rx_count, bus.rx_empty, bus.RAM_rx_data_out, bus.rx_src_node,
                     {bus.data_rx_complete_flag, bus.rx_error_flag, bus.rx_overflow_flag});
        end
        rst = 1'b1;
        idle();
        send_frame(16'h0005, 16'h0042, 16'hE201, 16'h0001, 1'b0);
        checks++;
        if ({bus.data_rx_complete_flag, bus.rx_src_node, bus.rx_count, bus.RAM_rx_data_out} !== {1'b1, 16'h0042, 5'd4, 16'hE201}) begin
            errors++;
            $display("FAIL after_reset cpl=%b src=%h count=%0d head=%h want 1/0042/4/e201",
                     bus.data_rx_complete_flag, bus.rx_src_node, bus.rx_count, bus.RAM_rx_data_out);
        end
        repeat (4) pop();
    endtask

    task automatic test_reserved_id();
        bus.node_id = 16'h0000;
        for (int i = 0; i < 6; i++) begin
            beat({16'h0000, 16'(i + 1)});
            checks++;
            if ({bus.data_rx_complete_flag, bus.rx_error_flag, bus.rx_overflow_flag, bus.rx_count} !== {3'b000, 5'd0}) begin
                errors++;
                $display("FAIL reserved_id beat%0d flags=%b count=%0d want 000/0", i,
                         {bus.data_rx_complete_flag, bus.rx_error_flag, bus.rx_overflow_flag}, bus.rx_count);
            end
        end
        bus.node_id = 16'h0005;
    endtask

    initial begin
        bus.node_id        = 16'h0005;
        bus.data_rx_packet = 32'h0;
        bus.gpp_trf_rx     = 1'b0;
        test_reset();
        test_basic();
        test_filter();
        test_back_to_back();
        test_overflow();
        test_wrap();
        test_mid_reset();
        test_reserved_id();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
